// File: rtl/pid_mc_pkg.sv
// pid_mc_pkg: mode and register-map constants, FSM encoding and saturation helper
// shared by the multi-channel PID controller.
package pid_mc_pkg;
  localparam logic [2:0] MODE_POS = 3'd0, MODE_VEL = 3'd1, MODE_DISP = 3'd2, MODE_CUR = 3'd5, MODE_DIRECT = 3'd6;
  localparam logic [3:0] A_KP = 4'd0, A_KI = 4'd1, A_KD = 4'd2, A_SHIFT = 4'd3, A_OUT_POS = 4'd4,
                         A_OUT_NEG = 4'd5, A_INT_POS = 4'd6, A_INT_NEG = 4'd7, A_DEAD = 4'd8;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0, S_ERR = 3'd1, S_MUL_P = 3'd2, S_MUL_I = 3'd3,
                     S_MUL_D = 3'd4, S_SUM = 3'd5, S_WRITE = 3'd6;
  // clamps v into the signed range of a w-bit number; caller truncates the result to w bits
  function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    return v > hi ? hi : v < -hi - 128'sd1 ? -hi - 128'sd1 : v;
  endfunction
endpackage

// File: rtl/pid_mc_datapath.sv
// pid_mc_datapath: shared signed multiplier, conditional integrator, shifter and
// output clamp, stepped through one channel at a time by the controller FSM.
module pid_mc_datapath
  import pid_mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  state_t                     state,
  input  logic signed [DATA_W-1:0]   err,
  input  logic signed [DATA_W-1:0]   d_err,
  input  logic signed [DATA_W-1:0]   kp,
  input  logic signed [DATA_W-1:0]   ki,
  input  logic signed [DATA_W-1:0]   kd,
  input  logic signed [DATA_W-1:0]   int_pos,
  input  logic signed [DATA_W-1:0]   int_neg,
  input  logic signed [DATA_W-1:0]   out_pos,
  input  logic signed [DATA_W-1:0]   out_neg,
  input  logic [4:0]                 shift,
  input  logic signed [2*DATA_W-1:0] integral_in,
  input  logic                       dead,
  input  logic                       int_en,
  output logic signed [2*DATA_W-1:0] integral_out,
  output logic signed [OUT_W-1:0]    result
);
  localparam int P = 2 * DATA_W;
  logic signed [DATA_W-1:0] mul_a, mul_b;
  logic signed [P-1:0] prod, pterm, dterm;
  logic signed [P:0] int_sum, int_hi, int_lo;
  logic signed [P+1:0] sum, shifted, out_hi, out_lo, lo_clamped;
  always_comb begin
    mul_a = state == S_MUL_P ? kp : state == S_MUL_I ? ki : kd;
    mul_b = state == S_MUL_D ? d_err : err;
    prod = P'(mul_a) * P'(mul_b);
    int_sum = (P+1)'(integral_in) + (P+1)'(prod);
    int_hi = (P+1)'(int_pos);
    int_lo = (P+1)'(int_neg);
    sum = (P+2)'(pterm) + (P+2)'(dterm) + (P+2)'(integral_out);
    shifted = sum >>> shift;
    out_lo = (P+2)'(out_neg);
    out_hi = (P+2)'(out_pos);
    lo_clamped = shifted < out_lo ? out_lo : shifted;
  end
  // positive limit applied last so an inverted limit pair resolves to out_pos
  always_ff @(posedge clock) begin
    if (!reset) begin
      pterm <= '0;
      dterm <= '0;
      integral_out <= '0;
      result <= '0;
    end else begin
      if (state == S_MUL_P) pterm <= dead ? '0 : prod;
      if (state == S_MUL_I) integral_out <= !int_en ? integral_in :
                                            P'(int_sum > int_hi ? int_hi : int_sum < int_lo ? int_lo : int_sum);
      if (state == S_MUL_D) dterm <= prod;
      if (state == S_SUM) result <= OUT_W'(saturate(128'(lo_clamped > out_hi ? out_hi : lo_clamped), OUT_W));
    end
  end
endmodule

// File: rtl/pid_controller_mc.sv
// pid_controller_mc: time-multiplexed PID engine sweeping NUM_CHANNELS motor channels
// through one shared datapath, six cycles per channel, with busy/done handshake.
module pid_controller_mc
  import pid_mc_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_W       = 32,
  parameter int OUT_W        = 16,
  parameter int CH_W         = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cfg_write,
  input  logic [CH_W-1:0]                  cfg_channel,
  input  logic [3:0]                       cfg_addr,
  input  logic [DATA_W-1:0]                cfg_data,
  output logic                             cfg_ready,
  input  logic [3*NUM_CHANNELS-1:0]        control_mode,
  input  logic [DATA_W*NUM_CHANNELS-1:0]   sp,
  input  logic [DATA_W*NUM_CHANNELS-1:0]   position,
  input  logic [16*NUM_CHANNELS-1:0]       velocity,
  input  logic [DATA_W*NUM_CHANNELS-1:0]   displacement,
  input  logic [16*NUM_CHANNELS-1:0]       current,
  input  logic                             update_controller,
  output logic                             busy,
  output logic                             done,
  output logic [OUT_W*NUM_CHANNELS-1:0]    pwmRef
);
  localparam int W = DATA_W;
  localparam int N = NUM_CHANNELS;
  logic signed [W-1:0] kp[N], ki[N], kd[N], out_pos[N], out_neg[N], int_pos[N], int_neg[N], dead_band[N];
  logic [4:0] shifter[N];
  logic signed [2*W-1:0] integral[N];
  logic signed [W-1:0] last_error[N];
  logic [2:0] prev_mode[N], mode_a[N];
  logic signed [OUT_W-1:0] pwm[N];
  logic signed [W-1:0] sp_a[N], pos_a[N], disp_a[N];
  logic signed [15:0] vel_a[N], cur_a[N];
  state_t state;
  logic [CH_W-1:0] ch;
  logic upd_prev, pending, ovr_q, frozen_q;
  logic [2:0] mode_q, m;
  logic signed [W-1:0] err_q, last_base_q, spv, meas, err_c, d_err;
  logic signed [2*W-1:0] integ_base_q, dp_integral;
  logic signed [OUT_W-1:0] ovr_val_q, dp_result;
  logic signed [W:0] abs_err;
  logic changed, reserved, disp_off, direct, dead, windup, edge_seen, last_ch;
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign sp_a[k] = sp[k*W +: W];
    assign pos_a[k] = position[k*W +: W];
    assign disp_a[k] = displacement[k*W +: W];
    assign vel_a[k] = velocity[k*16 +: 16];
    assign cur_a[k] = current[k*16 +: 16];
    assign mode_a[k] = control_mode[k*3 +: 3];
    assign pwmRef[k*OUT_W +: OUT_W] = pwm[k];
  end
  assign busy = state != S_IDLE;
  assign cfg_ready = !busy;
  always_comb begin
    m = mode_a[ch];
    spv = sp_a[ch];
    meas = m == MODE_POS ? pos_a[ch] : m == MODE_VEL ? W'(vel_a[ch]) : m == MODE_CUR ? W'(cur_a[ch]) : disp_a[ch];
    reserved = !(m inside {MODE_POS, MODE_VEL, MODE_DISP, MODE_CUR, MODE_DIRECT});
    direct = m == MODE_DIRECT;
    disp_off = m == MODE_DISP && spv <= 0;
    changed = m != prev_mode[ch];
    err_c = (reserved || disp_off || direct) ? '0 : W'(saturate(128'((W+1)'(spv) - (W+1)'(meas)), W));
    d_err = W'(saturate(128'((W+1)'(err_q) - (W+1)'(last_base_q)), W));
    abs_err = err_q < 0 ? -((W+1)'(err_q)) : (W+1)'(err_q);
    dead = abs_err < (W+1)'(dead_band[ch]);
    windup = (W'(pwm[ch]) == out_pos[ch] && err_q > 0) || (W'(pwm[ch]) == out_neg[ch] && err_q < 0);
    edge_seen = update_controller && !upd_prev;
    last_ch = ch == CH_W'(N - 1);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      ch <= '0;
      upd_prev <= 1'b0;
      pending <= 1'b0;
      done <= 1'b0;
      mode_q <= '0;
      err_q <= '0;
      last_base_q <= '0;
      integ_base_q <= '0;
      ovr_q <= 1'b0;
      ovr_val_q <= '0;
      frozen_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        kp[i] <= '0;
        ki[i] <= '0;
        kd[i] <= '0;
        shifter[i] <= '0;
        out_pos[i] <= '0;
        out_neg[i] <= '0;
        int_pos[i] <= '0;
        int_neg[i] <= '0;
        dead_band[i] <= '0;
        integral[i] <= '0;
        last_error[i] <= '0;
        prev_mode[i] <= '0;
        pwm[i] <= '0;
      end
    end else begin
      upd_prev <= update_controller;
      done <= 1'b0;
      if (cfg_write && !busy)
        case (cfg_addr)
          A_KP:      kp[cfg_channel] <= cfg_data;
          A_KI:      ki[cfg_channel] <= cfg_data;
          A_KD:      kd[cfg_channel] <= cfg_data;
          A_SHIFT:   shifter[cfg_channel] <= cfg_data[4:0];
          A_OUT_POS: out_pos[cfg_channel] <= cfg_data;
          A_OUT_NEG: out_neg[cfg_channel] <= cfg_data;
          A_INT_POS: int_pos[cfg_channel] <= cfg_data;
          A_INT_NEG: int_neg[cfg_channel] <= cfg_data;
          A_DEAD:    dead_band[cfg_channel] <= cfg_data;
          default: ;
        endcase
      case (state)
        S_IDLE: if (edge_seen || pending) begin
          state <= S_ERR;
          ch <= '0;
          pending <= 1'b0;
        end
        // a mode change or a clearing mode zeroes the stored state before it is used
        S_ERR: begin
          mode_q <= m;
          err_q <= err_c;
          last_base_q <= changed ? '0 : last_error[ch];
          integ_base_q <= (changed || reserved || disp_off || direct) ? '0 : integral[ch];
          frozen_q <= reserved || disp_off || direct;
          ovr_q <= reserved || direct;
          ovr_val_q <= direct ? OUT_W'(saturate(128'(spv), OUT_W)) : '0;
          state <= S_MUL_P;
        end
        S_MUL_P: state <= S_MUL_I;
        S_MUL_I: state <= S_MUL_D;
        S_MUL_D: state <= S_SUM;
        S_SUM:   state <= S_WRITE;
        S_WRITE: begin
          pwm[ch] <= ovr_q ? ovr_val_q : dp_result;
          integral[ch] <= dp_integral;
          last_error[ch] <= err_q;
          prev_mode[ch] <= mode_q;
          ch <= ch + 1'b1;
          state <= last_ch ? S_IDLE : S_ERR;
          done <= last_ch;
        end
        default: state <= S_IDLE;
      endcase
      if (busy && edge_seen) pending <= 1'b1;
    end
  end
  pid_mc_datapath #(.DATA_W(W), .OUT_W(OUT_W)) u_dp (
    .clock(clock),
    .reset(reset),
    .state(state),
    .err(err_q),
    .d_err(d_err),
    .kp(kp[ch]),
    .ki(ki[ch]),
    .kd(kd[ch]),
    .int_pos(int_pos[ch]),
    .int_neg(int_neg[ch]),
    .out_pos(out_pos[ch]),
    .out_neg(out_neg[ch]),
    .shift(shifter[ch]),
    .integral_in(integ_base_q),
    .dead(dead),
    .int_en(!dead && !windup && !frozen_q),
    .integral_out(dp_integral),
    .result(dp_result)
  );
endmodule

// File: tb/tb_pid_controller_mc.sv
// tb_pid_controller_mc: directed vectors with hand-computed expectations for the
// multi-channel PID controller (reset, P/I/D paths, anti-windup, modes, handshake).
module tb_pid_controller_mc;
  import pid_mc_pkg::*;
  localparam int N = 8, W = 32, O = 16;
  logic clock = 1'b0, reset = 1'b0, cfg_write = 1'b0, update_controller = 1'b0;
  logic [2:0] cfg_channel = '0;
  logic [3:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic [3*N-1:0] control_mode = '0;
  logic [W*N-1:0] sp = '0, position = '0, displacement = '0;
  logic [16*N-1:0] velocity = '0, current = '0;
  logic cfg_ready, busy, done;
  logic [O*N-1:0] pwmRef;
  int n_checks = 0, n_fail = 0;
  int bc, t, cnt;
  pid_controller_mc #(.NUM_CHANNELS(N), .DATA_W(W), .OUT_W(O), .CH_W(3)) dut (
    .clock(clock), .reset(reset), .cfg_write(cfg_write), .cfg_channel(cfg_channel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .control_mode(control_mode),
    .sp(sp), .position(position), .velocity(velocity), .displacement(displacement),
    .current(current), .update_controller(update_controller), .busy(busy), .done(done),
    .pwmRef(pwmRef)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask
  function automatic longint pwm(input int c);
    return longint'($signed(pwmRef[c*O +: O]));
  endfunction
  task automatic cfg(input int c, input logic [3:0] a, input int d);
    cfg_write = 1'b1;
    cfg_channel = 3'(c);
    cfg_addr = a;
    cfg_data = 32'(d);
    tick(1);
    cfg_write = 1'b0;
  endtask
  task automatic set_ch(input int c, input int s, input int p);
    sp[c*W +: W] = 32'(s);
    position[c*W +: W] = 32'(p);
  endtask
  task automatic wait_done(input string tag, output int busy_cycles);
    int k;
    busy_cycles = 0;
    k = 0;
    while (!done && k < 200) begin
      busy_cycles += int'(busy);
      tick(1);
      k++;
    end
    check(tag, longint'(done), 1);
  endtask
  task automatic sweep(input string tag, output int busy_cycles);
    update_controller = 1'b1;
    tick(1);
    update_controller = 1'b0;
    wait_done(tag, busy_cycles);
  endtask
  initial begin
    sp = {N{32'd123}};
    position = {N{32'd7}};
    update_controller = 1'b1;
    cfg_write = 1'b1;
    cfg_data = 32'd55;
    tick(3);
    check("rst_pwm_any", longint'(|pwmRef), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_cfg_ready", longint'(cfg_ready), 1);
    check("rst_done", longint'(done), 0);
    cfg_write = 1'b0;
    update_controller = 1'b0;
    sp = '0;
    position = '0;
    reset = 1'b1;
    tick(1);
    // P-only on channel 2: (100-40)*4 >>> 1 = 120
    cfg(2, A_KP, 4);
    cfg(2, A_SHIFT, 1);
    cfg(2, A_OUT_POS, 1000);
    cfg(2, A_OUT_NEG, -1000);
    set_ch(2, 100, 40);
    sweep("p_done", bc);
    check("p_busy_len", bc, 48);
    check("p_busy_after", longint'(busy), 0);
    check("p_ch2", pwm(2), 120);
    for (int c = 0; c < N; c++) if (c != 2) check($sformatf("p_other_ch%0d", c), pwm(c), 0);
    tick(1);
    check("p_done_one_cycle", longint'(done), 0);
    // integral clamps at 50, output clamps at 30, then anti-windup holds the integral
    cfg(0, A_KI, 10);
    cfg(0, A_INT_POS, 50);
    cfg(0, A_INT_NEG, -50);
    cfg(0, A_OUT_POS, 30);
    cfg(0, A_OUT_NEG, -30);
    set_ch(0, 20, 0);
    for (int s = 0; s < 3; s++) begin
      sweep($sformatf("i_done%0d", s), bc);
      check($sformatf("i_pwm%0d", s), pwm(0), 30);
      check($sformatf("i_integral%0d", s), longint'(dut.integral[0]), 50);
    end
    cfg(0, A_INT_POS, 1000);
    sweep("aw_done", bc);
    check("aw_pwm", pwm(0), 30);
    check("aw_integral", longint'(dut.integral[0]), 50);
    cfg(0, A_KI, 0);
    cfg(0, A_OUT_POS, 1000);
    sweep("aw_read_done", bc);
    check("aw_read_pwm", pwm(0), 50);
    // ch1 I+D: sweep1 30+2*30=90, sweep2 60+0=60, then mode 2 with sp=0 clears everything
    cfg(1, A_KI, 1);
    cfg(1, A_KD, 2);
    cfg(1, A_INT_POS, 1000);
    cfg(1, A_INT_NEG, -1000);
    cfg(1, A_OUT_POS, 1000);
    cfg(1, A_OUT_NEG, -1000);
    set_ch(1, 30, 0);
    sweep("id_done1", bc);
    check("id_pwm1", pwm(1), 90);
    sweep("id_done2", bc);
    check("id_pwm2", pwm(1), 60);
    control_mode[1*3 +: 3] = MODE_DISP;
    set_ch(1, 0, 0);
    displacement[1*W +: W] = 32'd5;
    sweep("mc_done", bc);
    check("mc_pwm", pwm(1), 0);
    check("mc_integral", longint'(dut.integral[1]), 0);
    check("mc_last_error", longint'(dut.last_error[1]), 0);
    // handshake: three extra edges during a sweep queue exactly one more; busy write dropped
    update_controller = 1'b1;
    tick(1);
    update_controller = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(3);
      update_controller = 1'b1;
      tick(1);
      update_controller = 1'b0;
    end
    check("hs_cfg_ready_busy", longint'(cfg_ready), 0);
    cfg(2, A_KP, 99);
    wait_done("hs_done1", bc);
    tick(1);
    check("hs_restart", longint'(busy), 1);
    wait_done("hs_done2", bc);
    check("hs_second_len", bc, 48);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      cnt += int'(busy);
    end
    check("hs_no_third", cnt, 0);
    check("hs_kp_kept", longint'(dut.kp[2]), 4);
    check("hs_ch2", pwm(2), 120);
    // direct mode saturates sp to the output width
    control_mode[3*3 +: 3] = MODE_DIRECT;
    set_ch(3, 70000, 0);
    sweep("dir_done_pos", bc);
    check("dir_pos", pwm(3), 32767);
    set_ch(3, -70000, 0);
    sweep("dir_done_neg", bc);
    check("dir_neg", pwm(3), -32768);
    // reset mid-sweep aborts with no done pulse
    update_controller = 1'b1;
    tick(1);
    update_controller = 1'b0;
    tick(10);
    check("ab_busy_before", longint'(busy), 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("ab_busy", longint'(busy), 0);
    check("ab_pwm_any", longint'(|pwmRef), 0);
    t = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      t += int'(done) + int'(busy);
    end
    check("ab_no_done", t, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pid_controller_mc.md
Name: pid_controller_mc

Overview:
- Time-multiplexed, parametrised PID engine serving NUM_CHANNELS motor channels with one shared signed multiplier.
- Successor to the single-channel myo PID. Adds per-channel register-mapped gains and limits, conditional-integration anti-windup, integral/derivative state clear on mode change, and a sweep handshake (busy/done).
- Sits between the sensor-decode blocks and the PWM generators. One controller update sweeps all channels.

Parameters:
- NUM_CHANNELS, 8, number of controlled channels.
- DATA_W, 32, width of setpoints, measurements, gains and limits.
- OUT_W, 16, width of each pwmRef.
- CH_W, 3, channel-index width; must satisfy 2^CH_W >= NUM_CHANNELS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cfg_write  in  1  config write strobe; honoured only when cfg_ready=1.
- cfg_channel  in  CH_W  target channel.
- cfg_addr  in  4  register select: 0 Kp, 1 Ki, 2 Kd, 3 outputShifter, 4 outputPosMax, 5 outputNegMax, 6 integralPosMax, 7 integralNegMax, 8 deadBand; others ignored.
- cfg_data  in  DATA_W  write data.
- cfg_ready  out  1  equals !busy.
- control_mode  in  3*NUM_CHANNELS  per-channel mode: 0 position, 1 velocity, 2 displacement, 5 current, 6 direct, others reserved.
- sp  in  DATA_W*NUM_CHANNELS  setpoints.
- position  in  DATA_W*NUM_CHANNELS.
- velocity  in  16*NUM_CHANNELS.
- displacement  in  DATA_W*NUM_CHANNELS.
- current  in  16*NUM_CHANNELS.
- update_controller  in  1  a rising edge requests a sweep.
- busy  out  1  high while a sweep runs.
- done  out  1  one-cycle pulse when a sweep completes.
- pwmRef  out  OUT_W*NUM_CHANNELS  signed outputs; channel k occupies bits [k*OUT_W +: OUT_W].

Behaviour:
- Reset (reset=0 at a clock edge): all config registers, integrals, lastError, prev_mode and pwmRef go to 0. busy=0, done=0, pending=0, FSM=IDLE.
- Edge detect: a rising edge is update_controller_prev=0 and update_controller=1.
  - Edge in IDLE starts a sweep on the next cycle.
  - Edge while busy sets pending; only one request is queued, and extra edges are dropped.
  - pending starts a new sweep the cycle after done.
- FSM per channel ch, with ch running 0..NUM_CHANNELS-1, takes 6 cycles:
  - ERR: compute err. Widen to DATA_W+1 and saturate to DATA_W.
  - MUL_P: pterm = Kp*err.
  - MUL_I: compute Ki*err and the conditional integral update.
  - MUL_D: dterm = Kd*(err-lastError).
  - SUM: sum, shift, clamp.
  - WRITE: update pwmRef[ch], lastError[ch] and prev_mode[ch]. Then go to ERR for ch+1, or to IDLE with done=1 after the last channel.
  - Sweep latency is 6*NUM_CHANNELS cycles from busy rising to done.
- Inputs (sp, measurements, mode) are sampled in ERR of their own channel only.
- Error by mode:
  - Mode 0: sp-position.
  - Mode 1: sp-sext(velocity).
  - Mode 5: sp-sext(current).
  - Mode 2: sp-displacement if sp>0. Otherwise err=0 and the integral is cleared.
  - Mode 6: pwmRef = saturate(sp) to OUT_W; integral and lastError are cleared.
  - Reserved modes: pwmRef=0 and the integral is cleared.
- Mode change: if control_mode[ch] != prev_mode[ch], clear integral[ch] and lastError[ch] before this sweep's computation.
- Deadband: if |err| < deadBand, then pterm=0 and the integral is not updated. dterm is still computed.
- Widths:
  - Products are 2*DATA_W signed.
  - The integral is 2*DATA_W, clamped to [sext(integralNegMax), sext(integralPosMax)].
  - Sum is pterm+dterm+integral in 2*DATA_W+2 bits, arithmetic right shift by outputShifter[4:0].
  - Then clamp to [outputNegMax, outputPosMax], then saturate to OUT_W.
- Anti-windup: the integral update is skipped when the previous pwmRef[ch] sits at outputPosMax and err>0, or at outputNegMax and err<0.
- Config:
  - Writes while busy are dropped.
  - A write in the same cycle as a start edge is accepted, and the sweep uses the new value.
  - If outputNegMax > outputPosMax, the output is outputPosMax (the positive clamp is applied last).
- Reset mid-sweep aborts the sweep immediately: no done pulse, and all state is zero.

Decomposition:
- Package pid_mc_pkg holds:
  - mode constants (MODE_POS=0, MODE_VEL=1, MODE_DISP=2, MODE_CUR=5, MODE_DIRECT=6);
  - cfg_addr constants;
  - the FSM state enum;
  - the saturate function.
- One sub-module, pid_mc_datapath: the shared multiplier, accumulator, shifter and clamp, driven by the FSM in the top level.

Test Plan:
- Reset: hold reset=0 for 3 cycles with non-zero inputs -> pwmRef all 0, busy=0, cfg_ready=1.
- Position P-only, NUM_CHANNELS=8:
  - Stimulus: ch2 Kp=4, shifter=1, limits ±1000, sp=100, position=40; pulse update_controller.
  - Response: busy for exactly 48 cycles, done pulse, pwmRef[2]=120, all other channels 0.
- Integral clamp plus anti-windup:
  - Stimulus: ch0 Ki=10, integralPosMax=50, outputPosMax=30, err=+20; run 3 sweeps.
  - Response: integral is 50 after sweep 1, pwmRef[0]=30, and the integral does not grow afterwards.
- Mode change and displacement:
  - Stimulus: ch1 runs mode 0 with an accumulated integral, then switches to mode 2 with sp=0.
  - Response: integral=0, lastError=0, pwmRef[1]=0.
- Handshake:
  - Stimulus: 3 rising edges on update_controller during one sweep, plus cfg_write during busy.
  - Response: exactly one extra sweep runs back-to-back after done; the config register is unchanged.
- Direct mode saturation: mode 6, sp=70000, OUT_W=16 -> pwmRef=32767. With sp=-70000 -> pwmRef=-32768.
